// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin two-port sequencer for the single-port data memory.
//               Optional per-port access counters when DMEM_ARB_STATS_EN is defined.
// Revision    : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
`ifdef DMEM_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [AW-1:0]    m0_addr,
    input  logic [DW-1:0]    m0_wdata,
    output logic             m0_done,
    output logic [DW-1:0]    m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [AW-1:0]    m1_addr,
    input  logic [DW-1:0]    m1_wdata,
    output logic             m1_done,
    output logic [DW-1:0]    m1_rdata,
    output logic             busy,
`ifdef DMEM_ARB_STATS_EN
    output logic [CNT_W-1:0] m0_count,
    output logic [CNT_W-1:0] m1_count,
`endif
    output logic             dm_wen,
    output logic [AW-1:0]    dm_address,
    output logic [DW-1:0]    dm_write_data,
    input  logic [DW-1:0]    dm_read_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic          r_owner;
    logic          r_we;
    logic          r_last;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          w_grant;
    logic          w_winner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // In RSP only the non-owner can be granted, so alternation falls out naturally.
    always_comb begin
        w_grant      = 1'b0;
        w_winner     = 1'b0;
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    w_grant      = 1'b1;
                    w_winner     = (m0_req && m1_req) ? ~r_last : m1_req;
                    w_state_next = ACC;
                end
            end
            ACC: begin
                w_state_next = RSP;
            end
            RSP: begin
                w_winner = ~r_owner;
                if (r_owner ? m0_req : m1_req) begin
                    w_grant      = 1'b1;
                    w_state_next = ACC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_last  <= 1'b1;
        end else begin
            if (w_grant) begin
                r_owner <= w_winner;
                r_we    <= w_winner ? m1_we    : m0_we;
                r_addr  <= w_winner ? m1_addr  : m0_addr;
                r_wdata <= w_winner ? m1_wdata : m0_wdata;
            end
            // Captured on the same edge that commits a write, hence pre-write data.
            if (r_state == ACC) begin
                r_rdata <= dm_read_data;
            end
            if (r_state == RSP) begin
                r_last <= r_owner;
            end
        end
    end

    always_comb begin
        busy    = (r_state != IDLE);
        dm_wen  = (r_state == ACC) && r_we;
        m0_done = (r_state == RSP) && !r_owner;
        m1_done = (r_state == RSP) &&  r_owner;
    end

    assign dm_address    = r_addr;
    assign dm_write_data = r_wdata;
    assign m0_rdata      = r_rdata;
    assign m1_rdata      = r_rdata;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_count <= '0;
            m1_count <= '0;
        end else begin
            if (m0_done) begin
                m0_count <= m0_count + 1'b1;
            end
            if (m1_done) begin
                m1_count <= m1_count + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
